// File: rtl/pd4_disp_pkg.sv
// Shared types and the hex-to-7-segment decode for the PD4 display stage.
// No timing of its own; pure combinational helpers.
// No flow control involved.
package pd4_disp_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [6:0] seg_t;
    typedef logic [2:0] digit_idx_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; lowercase b and d keep them distinct from 8 and 0.
    function automatic seg_t hex_to_seg(logic [3:0] nib);
        seg_t s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pd4_hex_scanner_if.sv
// PIO byte inputs and multiplexed display outputs of the hex scanner.
// Plain wires, no latency.
// No backpressure; the display side free-runs.
interface pd4_hex_scanner_if;
    import pd4_disp_pkg::*;

    logic [7:0] d_slave;
    logic [7:0] dd_slave;
    logic [7:0] def_slave;
    seg_t       seg;
    logic       dp;
    logic [5:0] an;
    logic       frame_strobe;
    logic       changed;

    modport master (
        output d_slave, dd_slave, def_slave,
        input  seg, dp, an, frame_strobe, changed
    );

    modport slave (
        input  d_slave, dd_slave, def_slave,
        output seg, dp, an, frame_strobe, changed
    );

endinterface

// File: rtl/pd4_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_DIV cycles.
// Tick is combinational from the count register (high while count = CLK_DIV-1).
// No backpressure; free-running.
module pd4_tick_gen #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 2) begin : g_bad_div
            $error("pd4_tick_gen: CLK_DIV must be >= 2");
        end
    endgenerate

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/pd4_hex_scanner.sv
// Six-digit multiplexed hex display of the three PD4 PIO bytes, snapshotted per frame.
// Display changes one cycle after each prescaler tick; each digit dwells CLK_DIV cycles.
// No backpressure; inputs are sampled only at frame start.
module pd4_hex_scanner
    import pd4_disp_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    pd4_hex_scanner_if.slave bus
);

    logic        tick;
    logic        tick_q;
    digit_idx_t  idx;
    logic [23:0] snap;
    logic        diff_q;
    logic [23:0] live;
    logic        wrap;
    logic [3:0]  nib;

    pd4_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign live = {bus.def_slave, bus.dd_slave, bus.d_slave};
    assign wrap = tick && (idx == digit_idx_t'(NUM_DIGITS - 1));

    // Index, snapshot and compare advance on the tick itself.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx    <= digit_idx_t'(NUM_DIGITS - 1);
            snap   <= '0;
            diff_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick;
            if (tick) begin
                idx <= wrap ? '0 : idx + 3'd1;
            end
            if (wrap) begin
                snap   <= live;
                diff_q <= (live != snap);
            end
        end
    end

    assign nib = snap[{idx, 2'b00} +: 4];

    // Outputs follow one cycle behind the index so an/seg always switch together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.an           <= 6'h3F;
            bus.seg          <= SEG_BLANK;
            bus.dp           <= 1'b1;
            bus.frame_strobe <= 1'b0;
            bus.changed      <= 1'b0;
        end else begin
            bus.frame_strobe <= tick_q && (idx == 3'd0);
            bus.changed      <= tick_q && (idx == 3'd0) && diff_q;
            if (tick_q) begin
                bus.an  <= ~(6'd1 << idx);
                bus.seg <= hex_to_seg(nib);
                bus.dp  <= !((idx == 3'd2) || (idx == 3'd4));
            end
        end
    end

endmodule

// File: tb/tb_pd4_hex_scanner.sv
// Directed bench for pd4_hex_scanner at CLK_DIV = 4 (and a CLK_DIV = 2 copy for period checks).
module tb_pd4_hex_scanner;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   edge_n = 0;

    logic [5:0] exp_an  [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    logic [6:0] exp_seg [6] = '{7'h08, 7'h30, 7'h40, 7'h40, 7'h00, 7'h0E};
    logic       exp_dp  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    pd4_hex_scanner_if bus1 ();
    pd4_hex_scanner_if bus2 ();

    pd4_hex_scanner #(.CLK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    pd4_hex_scanner #(.CLK_DIV(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    always #5 clk = ~clk;

    task automatic tick_edge();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic advance_to(input int e);
        while (edge_n < e) tick_edge();
    endtask

    task automatic set_inputs(input logic [7:0] d, input logic [7:0] dd, input logic [7:0] def);
        bus1.d_slave = d; bus1.dd_slave = dd; bus1.def_slave = def;
        bus2.d_slave = d; bus2.dd_slave = dd; bus2.def_slave = def;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset  = 1'b1;
        edge_n = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_inputs(8'h11, 8'h22, 8'h33);
        for (int i = 0; i < 3; i++) begin
            tick_edge();
            tests_run++;
            if ({bus1.an, bus1.seg, bus1.dp, bus1.frame_strobe, bus1.changed} !== {6'h3F, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL reset_hold cycle %0d: an=%b seg=%b dp=%b fs=%b ch=%b, want an=111111 seg=1111111 dp=1 fs=0 ch=0",
                         i, bus1.an, bus1.seg, bus1.dp, bus1.frame_strobe, bus1.changed);
            end
        end
    endtask

    task automatic test_first_frame();
        set_inputs(8'h3A, 8'h00, 8'hF8);
        release_reset();
        advance_to(4);
        tests_run++;
        if ({bus1.an, bus1.frame_strobe} !== {6'h3F, 1'b0}) begin
            tests_failed++;
            $display("FAIL dark_before_tick: an=%b fs=%b, want an=111111 fs=0", bus1.an, bus1.frame_strobe);
        end
        for (int d = 0; d < 6; d++) begin
            advance_to(5 + 4 * d);
            tests_run++;
            if ({bus1.an, bus1.seg, bus1.dp} !== {exp_an[d], exp_seg[d], exp_dp[d]}) begin
                tests_failed++;
                $display("FAIL digit%0d_show: an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                         d, bus1.an, bus1.seg, bus1.dp, exp_an[d], exp_seg[d], exp_dp[d]);
            end
            if (d == 0) begin
                tests_run++;
                if ({bus1.frame_strobe, bus1.changed} !== 2'b11) begin
                    tests_failed++;
                    $display("FAIL first_strobe: fs=%b ch=%b, want fs=1 ch=1", bus1.frame_strobe, bus1.changed);
                end
            end
            advance_to(6 + 4 * d);
            tests_run++;
            if (bus1.frame_strobe !== 1'b0) begin
                tests_failed++;
                $display("FAIL strobe_width digit%0d: fs=%b, want 0", d, bus1.frame_strobe);
            end
            advance_to(8 + 4 * d);
            tests_run++;
            if ({bus1.an, bus1.seg} !== {exp_an[d], exp_seg[d]}) begin
                tests_failed++;
                $display("FAIL digit%0d_dwell: an=%b seg=%b, want an=%b seg=%b",
                         d, bus1.an, bus1.seg, exp_an[d], exp_seg[d]);
            end
        end
    endtask

    task automatic test_mid_frame_change();
        advance_to(29);
        tests_run++;
        if ({bus1.frame_strobe, bus1.changed, bus1.an, bus1.seg} !== {1'b1, 1'b0, 6'h3E, 7'h08}) begin
            tests_failed++;
            $display("FAIL second_strobe: fs=%b ch=%b an=%b seg=%b, want fs=1 ch=0 an=111110 seg=0001000",
                     bus1.frame_strobe, bus1.changed, bus1.an, bus1.seg);
        end
        advance_to(33);
        tests_run++;
        if (bus1.an !== 6'h3D) begin
            tests_failed++;
            $display("FAIL digit1_before_change: an=%b, want 111101", bus1.an);
        end
        set_inputs(8'h3A, 8'h5C, 8'hF8);
        advance_to(37);
        tests_run++;
        if ({bus1.an, bus1.seg} !== {6'h3B, 7'h40}) begin
            tests_failed++;
            $display("FAIL old_digit2: an=%b seg=%b, want an=111011 seg=1000000", bus1.an, bus1.seg);
        end
        advance_to(41);
        tests_run++;
        if ({bus1.an, bus1.seg} !== {6'h37, 7'h40}) begin
            tests_failed++;
            $display("FAIL old_digit3: an=%b seg=%b, want an=110111 seg=1000000", bus1.an, bus1.seg);
        end
        advance_to(53);
        tests_run++;
        if ({bus1.frame_strobe, bus1.changed} !== 2'b11) begin
            tests_failed++;
            $display("FAIL changed_strobe: fs=%b ch=%b, want fs=1 ch=1", bus1.frame_strobe, bus1.changed);
        end
        advance_to(61);
        tests_run++;
        if ({bus1.an, bus1.seg, bus1.dp} !== {6'h3B, 7'h46, 1'b0}) begin
            tests_failed++;
            $display("FAIL new_digit2: an=%b seg=%b dp=%b, want an=111011 seg=1000110 dp=0", bus1.an, bus1.seg, bus1.dp);
        end
        advance_to(65);
        tests_run++;
        if ({bus1.an, bus1.seg} !== {6'h37, 7'h12}) begin
            tests_failed++;
            $display("FAIL new_digit3: an=%b seg=%b, want an=110111 seg=0010010", bus1.an, bus1.seg);
        end
    endtask

    task automatic test_reset_mid_frame();
        advance_to(66);
        reset = 1'b0;
        tick_edge();
        tests_run++;
        if ({bus1.an, bus1.seg, bus1.dp, bus1.frame_strobe, bus1.changed} !== {6'h3F, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL mid_reset: an=%b seg=%b dp=%b fs=%b ch=%b, want an=111111 seg=1111111 dp=1 fs=0 ch=0",
                     bus1.an, bus1.seg, bus1.dp, bus1.frame_strobe, bus1.changed);
        end
        release_reset();
        advance_to(4);
        tests_run++;
        if ({bus1.an, bus1.frame_strobe} !== {6'h3F, 1'b0}) begin
            tests_failed++;
            $display("FAIL rerelease_dark: an=%b fs=%b, want an=111111 fs=0", bus1.an, bus1.frame_strobe);
        end
        advance_to(5);
        tests_run++;
        if ({bus1.frame_strobe, bus1.changed, bus1.an, bus1.seg} !== {1'b1, 1'b1, 6'h3E, 7'h08}) begin
            tests_failed++;
            $display("FAIL rerelease_strobe: fs=%b ch=%b an=%b seg=%b, want fs=1 ch=1 an=111110 seg=0001000",
                     bus1.frame_strobe, bus1.changed, bus1.an, bus1.seg);
        end
    endtask

    task automatic test_frame_period();
        int last1 = 5;
        int last2 = -1;
        int n1 = 0;
        int n2 = 0;
        while (edge_n < 110 && (n1 < 4 || n2 < 4)) begin
            tick_edge();
            tests_run++;
            if ($countones(~bus1.an) > 1 || $countones(~bus2.an) > 1) begin
                tests_failed++;
                $display("FAIL an_onehot edge %0d: an=%b an2=%b, want at most one low", edge_n, bus1.an, bus2.an);
            end
            if (bus1.frame_strobe === 1'b1 && n1 < 4) begin
                tests_run++;
                if (edge_n - last1 !== 24) begin
                    tests_failed++;
                    $display("FAIL period_div4: interval=%0d, want 24", edge_n - last1);
                end
                last1 = edge_n;
                n1++;
            end
            if (bus2.frame_strobe === 1'b1 && n2 < 4) begin
                if (last2 >= 0) begin
                    tests_run++;
                    if (edge_n - last2 !== 12) begin
                        tests_failed++;
                        $display("FAIL period_div2: interval=%0d, want 12", edge_n - last2);
                    end
                    n2++;
                end
                last2 = edge_n;
            end
        end
        tests_run++;
        if (n1 < 4 || n2 < 4) begin
            tests_failed++;
            $display("FAIL period_timeout: div4 intervals=%0d div2 intervals=%0d, want 4 each", n1, n2);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_mid_frame_change();
        test_reset_mid_frame();
        test_frame_period();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pd4_hex_scanner.md
# pd4_hex_scanner

Downstream display stage for the PD4 processor system. It consumes the three 8-bit PIO outputs `d_slave`, `dd_slave` and `def_slave`, and shows them as six hex digits on a multiplexed, common-anode 7-segment display. Each frame latches a snapshot of all three bytes, so the display never shows a mix of old and new values. A per-frame strobe and change flag feed board-level debug.

## Interface
Parameters:
- `CLK_DIV`, default 50000: clock cycles per digit slot. Legal range is ≥ 2; elaboration fails otherwise.

Ports:
- `clk` in, 1 bit: system clock; the only clock.
- `reset` in, 1 bit: synchronous reset, active-low.
- `d_slave` in, 8 bits: shown on digits 1:0.
- `dd_slave` in, 8 bits: shown on digits 3:2.
- `def_slave` in, 8 bits: shown on digits 5:4.
- `seg` out, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
- `dp` out, 1 bit: decimal point, active-low.
- `an` out, 6 bits: digit enables, active-low, at most one low at a time.
- `frame_strobe` out, 1 bit: one-cycle pulse when digit 0 is first displayed.
- `changed` out, 1 bit: valid only while `frame_strobe` is high; set when the new snapshot differs from the previous snapshot.

## Operation
- **Prescaler**: counts 0 to `CLK_DIV`-1 and wraps. `tick` is high when the count equals `CLK_DIV`-1.
- **Digit index**: 3-bit, values 0 to 5, advances on `tick`; 5 wraps to 0. The reset value is 5, so the first tick selects digit 0.
- **Snapshot**: on a tick that moves the index to 0, register {`def_slave`, `dd_slave`, `d_slave`}. On the same edge, store a compare result: snapshot ≠ previous snapshot.
- **Digit-to-nibble mapping**:
  - 0 → `d_slave`[3:0]
  - 1 → `d_slave`[7:4]
  - 2 → `dd_slave`[3:0]
  - 3 → `dd_slave`[7:4]
  - 4 → `def_slave`[3:0]
  - 5 → `def_slave`[7:4]
- **Decode**: standard hex, active-low {g..a}. Examples:
  - 0 = 1000000
  - 3 = 0110000
  - 8 = 0000000
  - A = 0001000
  - F = 0001110
- **Decimal point**: `dp` = 0 on digits 2 and 4 (byte separators), 1 otherwise.
- **Output register stage**: `an`, `seg`, `dp`, `frame_strobe` and `changed` are all registered. They are driven from the digit index and snapshot registers, never from the live inputs.
- **Input sampling**: input changes between snapshots are ignored. The rest of the current frame shows old data; the next frame shows new data.
- **Reset values**:
  - `an` = 111111
  - `seg` = 1111111
  - `dp` = 1
  - `frame_strobe` = 0
  - `changed` = 0
  - prescaler = 0
  - index = 5
  - snapshot and previous snapshot = 0
- **Reset mid-frame**: every register returns to its reset value on the next edge. No partial digit is completed.
- **First frame after reset**: compared against a previous snapshot of 0. `changed` = 1 if any input is nonzero.

## Timing
- **Edge numbering**: edge 1 is the first rising edge that samples `reset` = 1.
- **First tick**: the prescaler reaches `CLK_DIV`-1 after edge `CLK_DIV`-1, so the first tick is sampled at edge `CLK_DIV`. The snapshot captures the inputs as they are before edge `CLK_DIV`.
- **First display**: after edge `CLK_DIV`+1:
  - `an` = 111110
  - `seg` shows digit 0
  - `frame_strobe` = 1 for exactly one cycle
  - `changed` is valid
- **Latency**: tick to display change is 1 cycle.
- **Dwell time**: each digit is held for exactly `CLK_DIV` cycles.
- **Frame period**: 6×`CLK_DIV` cycles; the strobe-to-strobe interval is exactly that.
- **Digit transitions**: `an` and `seg` update on the same edge. There are no blank cycles between digits.
- **Before the first tick**: all digits are dark (`an` = 111111).

## Structure
- **Package `pd4_disp_pkg`**:
  - `NUM_DIGITS` = 6
  - `seg_t` (`logic [6:0]`)
  - `SEG_BLANK` = 7'h7F
  - pure function `hex_to_seg(logic [3:0]) → seg_t`
- **Sub-module `pd4_tick_gen`**: parameterised by `CLK_DIV`. Synchronous active-low reset. One-cycle `tick` output.
- **Top-level logic**: index, snapshot, compare and the output register stay in `pd4_hex_scanner`.

## Test plan
All scenarios use `CLK_DIV` = 4.
1. **Reset hold**: hold `reset` = 0 for 3 cycles with nonzero inputs → `an` = 111111, `seg` = 1111111, `dp` = 1, `frame_strobe` = 0, `changed` = 0 throughout.
2. **First frame content**: set `d_slave` = 8'h3A, `dd_slave` = 8'h00, `def_slave` = 8'hF8, then release reset → `frame_strobe` pulses after edge 5 with `changed` = 1. Digits 0 to 5 then show A, 3, 0, 0, 8, F, each for 4 cycles. The `an` low bit walks from bit 0 to bit 5. `dp` = 0 only on digits 2 and 4.
3. **Unchanged and mid-frame change**: hold the inputs constant → second strobe 24 cycles later with `changed` = 0. Then set `dd_slave` = 8'h5C while digit 1 is displayed → digits 2 and 3 still show 0, 0 in that frame. The next frame shows C, 5, with `changed` = 1 at its strobe.
4. **Reset mid-frame**: assert `reset` = 0 while digit 3 is displayed → the next edge gives all reset values. After release, the first strobe again follows edge 5.
5. **Frame period**: measure strobe intervals over 4 frames → exactly 24 cycles each. Repeat with `CLK_DIV` = 2 → 12 cycles. At all times, at most one `an` bit is low.
